// File: rtl/vec_op_issue_if.sv
// Operand-issue bus: dispatch op request, VRF read port pair and FU input beat.
// The slave modport is the issue sequencer; the master modport is its environment.
interface vec_op_issue_if #(
    parameter int unsigned VECTOR_WIDTH = 64,
    parameter int unsigned VECTOR_BYTE  = VECTOR_WIDTH / 8,
    parameter int unsigned ADDR_WITH    = 32,
    parameter int unsigned VL_W         = 16
);
    logic                    op_valid;
    logic                    op_ready;
    logic [ADDR_WITH-1:0]    op_src1_addr;
    logic [ADDR_WITH-1:0]    op_src2_addr;
    logic [ADDR_WITH-1:0]    op_dst_addr;
    logic [VL_W-1:0]         op_vl;
    logic [1:0]              op_sew;
    logic                    stall;
    logic                    vrf_rd_en;
    logic [ADDR_WITH-1:0]    vrf_rd_addr1;
    logic [ADDR_WITH-1:0]    vrf_rd_addr2;
    logic [VECTOR_WIDTH-1:0] vrf_rd_data1;
    logic [VECTOR_WIDTH-1:0] vrf_rd_data2;
    logic [VECTOR_WIDTH-1:0] in_vec1;
    logic [VECTOR_WIDTH-1:0] in_vec2;
    logic [VECTOR_BYTE-1:0]  byte_en;
    logic                    in_valid;
    logic [ADDR_WITH-1:0]    in_addr;
    logic                    busy;
    logic                    done;

    modport slave (
        input  op_valid, op_src1_addr, op_src2_addr, op_dst_addr, op_vl, op_sew,
               stall, vrf_rd_data1, vrf_rd_data2,
        output op_ready, vrf_rd_en, vrf_rd_addr1, vrf_rd_addr2, in_vec1, in_vec2,
               byte_en, in_valid, in_addr, busy, done
    );

    modport master (
        output op_valid, op_src1_addr, op_src2_addr, op_dst_addr, op_vl, op_sew,
               stall, vrf_rd_data1, vrf_rd_data2,
        input  op_ready, vrf_rd_en, vrf_rd_addr1, vrf_rd_addr2, in_vec1, in_vec2,
               byte_en, in_valid, in_addr, busy, done
    );
endinterface

// File: rtl/vec_op_issue.sv
// Vector operand issue sequencer: walks both source operands through the VRF one
// beat per unstalled cycle and presents them to the FU with tail byte masking.
module vec_op_issue #(
    parameter int unsigned VECTOR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned VECTOR_BYTE  = VECTOR_WIDTH / 8,
    parameter int unsigned ADDR_WITH    = 32,
    parameter int unsigned VL_W         = 16
) (
    input  logic          clk,
    input  logic          rst,
    vec_op_issue_if.slave bus
);
    localparam int unsigned TB_W    = VL_W + 3;
    localparam int unsigned BSH     = $clog2(VECTOR_BYTE);
    localparam int unsigned NB_W    = TB_W - BSH;
    localparam int unsigned SEW_MAX = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WITH-1:0]   src1, src2, dst;
    logic [TB_W-1:0]        tot_bytes;
    logic [NB_W-1:0]        nb, beat;
    logic                   accept_c, rd_en_c;
    logic [1:0]             sew_c;
    logic [TB_W-1:0]        op_bytes_c, rem_c;
    logic [TB_W:0]          round_c;
    logic [NB_W-1:0]        nb_c;
    logic [VECTOR_BYTE-1:0] mask_c;

    // Op sizing: SEW wider than the element limit is clamped to the limit.
    always_comb begin
        sew_c      = (32'(bus.op_sew) > SEW_MAX) ? 2'(SEW_MAX) : bus.op_sew;
        op_bytes_c = TB_W'(bus.op_vl) << sew_c;
        round_c    = (TB_W + 1)'(op_bytes_c) + (TB_W + 1)'(VECTOR_BYTE - 1);
        nb_c       = NB_W'(round_c >> BSH);
    end

    // Tail mask from bytes remaining at the current beat.
    always_comb begin
        rem_c = tot_bytes - (TB_W'(beat) << BSH);
        if (rem_c >= TB_W'(VECTOR_BYTE))
            mask_c = '1;
        else
            mask_c = ~({VECTOR_BYTE{1'b1}} << rem_c[BSH-1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        rd_en_c   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.op_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = (op_bytes_c == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    rd_en_c = 1'b1;
                    if (beat == nb - NB_W'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latched op fields and beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src1      <= '0;
            src2      <= '0;
            dst       <= '0;
            tot_bytes <= '0;
            nb        <= '0;
            beat      <= '0;
        end else if (accept_c) begin
            src1      <= bus.op_src1_addr;
            src2      <= bus.op_src2_addr;
            dst       <= bus.op_dst_addr;
            tot_bytes <= op_bytes_c;
            nb        <= nb_c;
            beat      <= '0;
        end else if (rd_en_c) begin
            beat      <= beat + NB_W'(1);
        end
    end

    // FU beat stage lines up with the VRF's one-cycle read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.in_valid <= 1'b0;
            bus.in_addr  <= '0;
            bus.byte_en  <= '0;
            bus.done     <= 1'b0;
        end else begin
            bus.in_valid <= rd_en_c;
            bus.done     <= (state_nxt == DRAIN);
            if (rd_en_c) begin
                bus.in_addr <= dst + ADDR_WITH'(beat);
                bus.byte_en <= mask_c;
            end
        end
    end

    assign bus.op_ready     = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.vrf_rd_en    = rd_en_c;
    assign bus.vrf_rd_addr1 = src1 + ADDR_WITH'(beat);
    assign bus.vrf_rd_addr2 = src2 + ADDR_WITH'(beat);
    assign bus.in_vec1      = bus.vrf_rd_data1;
    assign bus.in_vec2      = bus.vrf_rd_data2;
endmodule

// File: tb/tb_vec_op_issue.sv
// Directed bench for vec_op_issue: driver queues expected reads/beats/done,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_vec_op_issue;
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] v1;
        logic [63:0] v2;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_op_issue_if bus ();

    vec_op_issue dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int          n_vec = 0;
    int          n_err = 0;
    beat_t       beat_q[$];
    logic [63:0] rd_q[$];
    int          exp_done = 0;

    function automatic logic [63:0] f1(input logic [31:0] a);
        return {a, ~a};
    endfunction

    function automatic logic [63:0] f2(input logic [31:0] a);
        return {a ^ 32'h5A5A_A5A5, a + 32'd7};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event not expected / not seen", name);
    endtask

    // VRF model: one-cycle read latency on both ports.
    always @(posedge clk) begin
        if (bus.vrf_rd_en) begin
            bus.vrf_rd_data1 <= f1(bus.vrf_rd_addr1);
            bus.vrf_rd_data2 <= f2(bus.vrf_rd_addr2);
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.stall) chk("rd_en_in_stall", 64'(bus.vrf_rd_en), 64'd0);
            if (bus.vrf_rd_en) begin
                if (rd_q.size() == 0) bad("rd_unexpected");
                else begin
                    logic [63:0] r;
                    r = rd_q.pop_front();
                    chk("rd_addr1", 64'(bus.vrf_rd_addr1), 64'(r[63:32]));
                    chk("rd_addr2", 64'(bus.vrf_rd_addr2), 64'(r[31:0]));
                end
            end
            if (bus.in_valid) begin
                if (beat_q.size() == 0) bad("in_valid_unexpected");
                else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    chk("in_addr", 64'(bus.in_addr), 64'(b.addr));
                    chk("byte_en", 64'(bus.byte_en), 64'(b.be));
                    chk("in_vec1", bus.in_vec1, b.v1);
                    chk("in_vec2", bus.in_vec2, b.v2);
                end
            end
            if (bus.done) begin
                if (exp_done == 0) bad("done_unexpected");
                else begin
                    exp_done--;
                    chk("beats_left_at_done", 64'(beat_q.size()), 64'd0);
                end
            end
        end
    end

    task automatic push_op(input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] d,
                           input int nb, input logic [7:0] last_be);
        for (int k = 0; k < nb; k++) begin
            beat_t b;
            rd_q.push_back({s1 + 32'(k), s2 + 32'(k)});
            b.addr = d + 32'(k);
            b.be   = (k == nb - 1) ? last_be : 8'hFF;
            b.v1   = f1(s1 + 32'(k));
            b.v2   = f2(s2 + 32'(k));
            beat_q.push_back(b);
        end
        exp_done++;
    endtask

    task automatic issue(input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] d,
                         input logic [15:0] vl, input logic [1:0] sew);
        @(negedge clk);
        chk("op_ready_idle", 64'(bus.op_ready), 64'd1);
        bus.op_src1_addr = s1;
        bus.op_src2_addr = s2;
        bus.op_dst_addr  = d;
        bus.op_vl        = vl;
        bus.op_sew       = sew;
        bus.op_valid     = 1'b1;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
    endtask

    // One op end to end; stall held over cycles [st_start, st_start+st_len) after accept.
    task automatic run_op(input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] d,
                          input logic [15:0] vl, input logic [1:0] sew, input int nb,
                          input logic [7:0] last_be, input int st_start, input int st_len);
        int cyc;
        bit got;
        push_op(s1, s2, d, nb, last_be);
        issue(s1, s2, d, vl, sew);
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 300) begin
            bus.stall = (cyc >= st_start) && (cyc < st_start + st_len);
            @(negedge clk);
            if (cyc == 1) chk("op_ready_low_busy", 64'({bus.op_ready, bus.busy}), 64'b01);
            if (bus.done) got = 1'b1;
            else begin
                @(posedge clk);
                #1 cyc++;
            end
        end
        bus.stall = 1'b0;
        if (!got) bad("done_timeout");
        else chk("done_latency", 64'(cyc), 64'(nb + 1 + st_len));
        @(posedge clk);
        #1;
        chk("idle_after_done", 64'({bus.op_ready, bus.busy, bus.done}), 64'b100);
    endtask

    task automatic reset_checks();
        chk("rst_ready_busy", 64'({bus.op_ready, bus.busy}), 64'b10);
        chk("rst_strobes", 64'({bus.vrf_rd_en, bus.in_valid, bus.done}), 64'd0);
        chk("rst_byte_en", 64'(bus.byte_en), 64'd0);
        chk("rst_in_addr", 64'(bus.in_addr), 64'd0);
        chk("rst_rd_addrs", {bus.vrf_rd_addr1, bus.vrf_rd_addr2}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus.op_valid     = 1'b0;
        bus.op_src1_addr = '0;
        bus.op_src2_addr = '0;
        bus.op_dst_addr  = '0;
        bus.op_vl        = '0;
        bus.op_sew       = '0;
        bus.stall        = 1'b0;
        #12;
        reset_checks();
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h10, 32'h20, 32'h30, 16'd5, 2'd2, 3, 8'h0F, 0, 0);
        run_op(32'h100, 32'h200, 32'h300, 16'd8, 2'd3, 8, 8'hFF, 2, 2);
        run_op(32'h40, 32'h50, 32'h60, 16'd0, 2'd2, 0, 8'h00, 0, 0);
        run_op(32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 16'd16, 2'd0, 2, 8'hFF, 0, 0);
        run_op(32'h1000, 32'h2000, 32'h3000, 16'd3, 2'd0, 1, 8'h07, 0, 0);
        run_op(32'h1100, 32'h2100, 32'h3100, 16'd9, 2'd1, 3, 8'h03, 0, 0);

        // Reset mid-op: everything returns to reset values immediately, no done.
        push_op(32'h4000, 32'h5000, 32'h6000, 64, 8'hFF);
        issue(32'h4000, 32'h5000, 32'h6000, 16'd64, 2'd3);
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        reset_checks();
        beat_q.delete();
        rd_q.delete();
        exp_done = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("no_done_after_rst", 64'({bus.done, bus.busy}), 64'd0);

        run_op(32'h7000, 32'h8000, 32'h9000, 16'd4, 2'd3, 4, 8'hFF, 0, 0);
        repeat (3) @(negedge clk);
        chk("queues_empty", 64'(beat_q.size() + rd_q.size() + exp_done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
